// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and parity helper.
package uart_pkg;

    localparam int unsigned PARITY_NONE   = 0;
    localparam int unsigned PARITY_ODD    = 1;
    localparam int unsigned PARITY_EVEN   = 2;
    localparam int unsigned MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Callers zero-extend narrower words; the extra zeros do not change the XOR.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic [1:0]               mode);
        calc_parity = (mode == 2'(PARITY_ODD)) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a one-word holding register, paced by baud_tick.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY > PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    tx_state_t            state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] hold;
    logic                 hold_full;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_bit;
    logic                 accept;

    assign in_ready = ~hold_full;
    assign busy     = (state != ST_IDLE) || hold_full;
    assign accept   = in_valid && ~hold_full;

    // Single-process FSM; every output-affecting register is updated here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            shift      <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // Accept and engine load are mutually exclusive: load needs a full hold.
            if (accept) begin
                hold      <= in_data;
                hold_full <= 1'b1;
            end

            if (baud_tick) begin
                case (state)
                    ST_IDLE: begin
                        if (hold_full) begin
                            shift      <= hold;
                            parity_bit <= calc_parity(MAX_DATA_BITS'(hold), 2'(PARITY));
                            hold_full  <= 1'b0;
                            tx         <= 1'b0;
                            state      <= ST_START;
                        end
                    end
                    ST_START: begin
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != PARITY_NONE) begin
                                tx    <= parity_bit;
                                state <= ST_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (bit_cnt == CNT_W'(STOP_BITS - 1)) begin
                            frame_done <= 1'b1;
                            bit_cnt    <= '0;
                            // A waiting word starts on this same tick, leaving no idle gap.
                            if (hold_full) begin
                                shift      <= hold;
                                parity_bit <= calc_parity(MAX_DATA_BITS'(hold), 2'(PARITY));
                                hold_full  <= 1'b0;
                                tx         <= 1'b0;
                                state      <= ST_START;
                            end else begin
                                tx    <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        tx    <= 1'b1;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame across several parameter sets sharing clock, reset and tick.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    logic reset_n;
    logic baud_tick;

    logic       v_e8, v_o8, v_n7, v_n8;
    logic [7:0] d_e8, d_o8, d_n8;
    logic [6:0] d_n7;
    logic       r_e8, r_o8, r_n7, r_n8;
    logic       tx_e8, tx_o8, tx_n7, tx_n8;
    logic       b_e8, b_o8, b_n7, b_n8;
    logic       fd_e8, fd_o8, fd_n7, fd_n8;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt_e8 = 0, fd_cnt_o8 = 0, fd_cnt_n7 = 0, fd_cnt_n8 = 0;
    int busy_drops = 0;
    logic watch_busy = 1'b0;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e8 (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .in_valid(v_e8),
        .in_data(d_e8), .in_ready(r_e8), .tx(tx_e8), .busy(b_e8), .frame_done(fd_e8));
    uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_o8 (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .in_valid(v_o8),
        .in_data(d_o8), .in_ready(r_o8), .tx(tx_o8), .busy(b_o8), .frame_done(fd_o8));
    uart_tx_frame #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_n7 (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .in_valid(v_n7),
        .in_data(d_n7), .in_ready(r_n7), .tx(tx_n7), .busy(b_n7), .frame_done(fd_n7));
    uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n8 (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .in_valid(v_n8),
        .in_data(d_n8), .in_ready(r_n8), .tx(tx_n8), .busy(b_n8), .frame_done(fd_n8));

    always @(negedge clk) begin
        if (fd_e8) fd_cnt_e8++;
        if (fd_o8) fd_cnt_o8++;
        if (fd_n7) fd_cnt_n7++;
        if (fd_n8) fd_cnt_n8++;
        if (watch_busy && !b_n8) busy_drops++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        baud_tick = 1'b1;
        @(posedge clk); #1;
        baud_tick = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic accept_n8(input logic [7:0] d);
        v_n8 = 1'b1; d_n8 = d;
        @(posedge clk); #1;
        v_n8 = 1'b0;
    endtask

    logic [0:11] exp_e8 = 12'b010100101011;
    logic [0:11] exp_o8 = 12'b010100101111;
    logic [0:11] exp_n7 = 12'b010000011111;
    logic [0:20] exp_b2b = 21'b010101010101111000011;
    logic [0:10] exp_zero = 11'b00000000011;
    int fd_before;

    initial begin
        reset_n = 1'b0; baud_tick = 1'b0;
        v_e8 = 0; v_o8 = 0; v_n7 = 0; v_n8 = 0;
        d_e8 = '0; d_o8 = '0; d_n7 = '0; d_n8 = '0;
        gap(2);
        reset_n = 1'b1;
        gap(1);

        check("reset_tx",    {28'd0, tx_e8, tx_o8, tx_n7, tx_n8}, 32'hF);
        check("reset_busy",  {28'd0, b_e8, b_o8, b_n7, b_n8}, 32'h0);
        check("reset_ready", {28'd0, r_e8, r_o8, r_n7, r_n8}, 32'hF);
        check("reset_fd",    {28'd0, fd_e8, fd_o8, fd_n7, fd_n8}, 32'h0);

        // Single frames: even 0xA5, odd 0xA5, 7N2 0x41, launched together
        v_e8 = 1; d_e8 = 8'hA5; v_o8 = 1; d_o8 = 8'hA5; v_n7 = 1; d_n7 = 7'h41;
        @(posedge clk); #1;
        v_e8 = 0; v_o8 = 0; v_n7 = 0;
        d_e8 = 8'h00; d_o8 = 8'hFF; d_n7 = 7'h7F;
        check("accept_ready", {29'd0, r_e8, r_o8, r_n7}, 32'h0);
        check("accept_busy",  {29'd0, b_e8, b_o8, b_n7}, 32'h7);
        check("accept_tx",    {29'd0, tx_e8, tx_o8, tx_n7}, 32'h7);
        gap(15);
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("e8_tx_%0d", i), 32'(tx_e8), 32'(exp_e8[i]));
            check($sformatf("o8_tx_%0d", i), 32'(tx_o8), 32'(exp_o8[i]));
            check($sformatf("n7_tx_%0d", i), 32'(tx_n7), 32'(exp_n7[i]));
            check($sformatf("e8_fd_%0d", i), 32'(fd_e8), 32'(i == 11));
            check($sformatf("n7_fd_%0d", i), 32'(fd_n7), 32'(i == 10));
            check($sformatf("e8_busy_%0d", i), 32'(b_e8), 32'(i < 11));
            check($sformatf("n7_busy_%0d", i), 32'(b_n7), 32'(i < 10));
            gap(15);
        end
        check("e8_fd_count", 32'(fd_cnt_e8), 32'd1);
        check("o8_fd_count", 32'(fd_cnt_o8), 32'd1);
        check("n7_fd_count", 32'(fd_cnt_n7), 32'd1);

        // Back-to-back 0x55 then 0x0F on 8N1
        accept_n8(8'h55);
        check("b2b_ready_full", 32'(r_n8), 32'd0);
        watch_busy = 1'b1;
        gap(15);
        for (int i = 0; i < 21; i++) begin
            tick();
            check($sformatf("b2b_tx_%0d", i), 32'(tx_n8), 32'(exp_b2b[i]));
            check($sformatf("b2b_fd_%0d", i), 32'(fd_n8), 32'(i == 10 || i == 20));
            check($sformatf("b2b_busy_%0d", i), 32'(b_n8), 32'(i < 20));
            check($sformatf("b2b_ready_%0d", i), 32'(r_n8), 32'(i == 0 || i >= 10));
            if (i == 0) begin
                accept_n8(8'h0F);
                d_n8 = 8'hAA;
                check("b2b_second_accept_ready", 32'(r_n8), 32'd0);
                gap(14);
            end else begin
                if (i == 19) watch_busy = 1'b0;
                gap(15);
            end
        end
        check("b2b_busy_drops", 32'(busy_drops), 32'd0);
        check("b2b_fd_count", 32'(fd_cnt_n8), 32'd2);

        // Accept in a tick cycle waits for the following tick
        v_n8 = 1'b1; d_n8 = 8'hFF; baud_tick = 1'b1;
        @(posedge clk); #1;
        v_n8 = 1'b0; baud_tick = 1'b0;
        check("tickacc_tx", 32'(tx_n8), 32'd1);
        check("tickacc_ready", 32'(r_n8), 32'd0);
        check("tickacc_busy", 32'(b_n8), 32'd1);
        gap(15);
        check("tickacc_tx_held", 32'(tx_n8), 32'd1);
        tick();
        check("tickacc_start", 32'(tx_n8), 32'd0);
        check("tickacc_ready_after", 32'(r_n8), 32'd1);
        gap(15);
        tick();
        check("ff_bit0", 32'(tx_n8), 32'd1);
        gap(15);
        tick();
        check("ff_bit1", 32'(tx_n8), 32'd1);
        accept_n8(8'h12);
        check("ff_hold_full", 32'(r_n8), 32'd0);
        gap(5);

        // One-cycle reset mid-DATA, with a tick during reset
        fd_before = fd_cnt_n8;
        reset_n = 1'b0; baud_tick = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1; baud_tick = 1'b0;
        check("rst_tx", 32'(tx_n8), 32'd1);
        check("rst_busy", 32'(b_n8), 32'd0);
        check("rst_ready", 32'(r_n8), 32'd1);
        check("rst_fd", 32'(fd_n8), 32'd0);
        for (int i = 0; i < 2; i++) begin
            gap(15);
            tick();
            check($sformatf("idle_tick_tx_%0d", i), 32'(tx_n8), 32'd1);
            check($sformatf("idle_tick_busy_%0d", i), 32'(b_n8), 32'd0);
        end
        check("rst_no_fd", 32'(fd_cnt_n8), 32'(fd_before));

        // Fresh 0x00 after reset
        gap(3);
        accept_n8(8'h00);
        gap(15);
        for (int i = 0; i < 11; i++) begin
            tick();
            check($sformatf("zero_tx_%0d", i), 32'(tx_n8), 32'(exp_zero[i]));
            check($sformatf("zero_fd_%0d", i), 32'(fd_n8), 32'(i == 10));
            gap(15);
        end
        check("zero_fd_count", 32'(fd_cnt_n8), 32'(fd_before + 1));
        check("others_idle_tx", {29'd0, tx_e8, tx_o8, tx_n7}, 32'h7);
        check("others_fd_count", 32'(fd_cnt_e8 + fd_cnt_o8 + fd_cnt_n7), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, next generation of the 8N1 transmitter. It supports configurable data width, parity mode and stop-bit count. A single-entry holding register behind a valid/ready handshake lets back-to-back frames leave with no idle gap. It sits between a byte/word producer and the serial pin, and is paced by an external `baud_tick` strobe from the shared baud generator.

## Interface
- `DATA_BITS`, 8, data bits per frame; legal 5..9.
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, stop bits per frame; legal 1..2.
- Illegal parameter values are an elaboration-time error.

- `clk`  in  1  sole clock; all logic on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `baud_tick`  in  1  one-`clk` strobe, one per bit period.
- `in_valid`  in  1  producer has a word.
- `in_data`  in  DATA_BITS  word to send, LSB transmitted first.
- `in_ready`  out  1  holding register empty; word accepted when `in_valid && in_ready`.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  engine mid-frame or holding register full.
- `frame_done`  out  1  one-cycle pulse when the last stop bit ends.

## Operation
- Reset (`reset_n` low at an edge) gives:
  - `tx`=1, `busy`=0, `frame_done`=0.
  - Holding register empty, so `in_ready`=1.
  - State IDLE, bit counter 0.
  - A frame in progress is abandoned; the line returns high on the same edge.
- `in_ready` = !hold_full. It is derived from registered state only and has no combinational path from `in_valid`.
- On accept, `in_data` is written to the holding register and hold_full is set.
- States: IDLE → START → DATA → PARITY (skipped when `PARITY`=0) → STOP → IDLE or START.
- Transitions happen only on cycles with `baud_tick`=1. `tx` changes only on those cycles.
- In IDLE with hold_full at a `baud_tick`:
  - Copy the holding register into the shift register and clear hold_full.
  - Drive `tx`=0 and enter START.
- START: the next tick drives data bit 0 and enters DATA with counter 0.
- DATA: each tick drives the next bit. After bit `DATA_BITS`-1 has had its full period, the next tick goes to PARITY (or STOP) and drives that bit.
- Parity bit: XOR of the data bits for even; inverted XOR for odd.
- STOP: `tx`=1 for `STOP_BITS` bit periods. The tick that ends the last stop bit pulses `frame_done`, then:
  - if hold_full: load, drive `tx`=0, enter START on that same tick (no gap);
  - otherwise: enter IDLE with `tx` staying 1.
- `busy` = (state != IDLE) || hold_full. It stays 1 across a back-to-back boundary.
- `baud_tick` during reset is ignored. Ticks while IDLE and empty have no effect.

## Timing
- Frame length = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bit periods.
- Start latency: the start bit begins on the first `baud_tick` strictly after the accept cycle.
  - An accept in a tick cycle does not start until the following tick.
- Accept and hold-to-engine transfer in the same cycle cannot happen: `in_ready` is 0 in that cycle and becomes 1 the next cycle.
- A new word may be accepted any time during a frame once the hold is empty, giving one frame of buffering.
- `frame_done` is high for exactly one `clk` and coincides with the closing `baud_tick`.
- `in_data` is sampled only at accept; later changes do not affect the frame.

## Structure
- Shared package `uart_pkg` holds:
  - parity-mode constants (NONE/ODD/EVEN);
  - state encoding for IDLE/START/DATA/PARITY/STOP;
  - a parity function over a DATA_BITS vector.
- Single module, no sub-module. The holding register and counter are too small to split out. Baud generation remains the existing separate block.
- Counter width is $clog2(DATA_BITS) and must not wrap within a frame.

## Test plan
- 8-bit, even parity, 1 stop; send 0xA5; one `baud_tick` every 16 clks → `tx` per tick: 0,1,0,1,0,0,1,0,1,0,1, then idle high; one `frame_done` pulse.
- Same with `PARITY`=1 and 0xA5 → parity bit 1; total 11 bit periods.
- `DATA_BITS`=7, no parity, 2 stop; send 0x41 → 0,1,0,0,0,0,0,1,1,1 (10 periods).
- Two words accepted back-to-back (0x55 then 0x0F, 8N1):
  - the second is accepted during the first frame;
  - the start bit of 0x0F is driven on the same tick that ends the first stop bit;
  - `busy` stays 1 throughout;
  - `in_ready` is 0 while the hold is full.
- Accept in a cycle with `baud_tick`=1 → `tx` stays high until the next tick, then goes 0.
- `reset_n` low for 1 clk mid-DATA of 0xFF → `tx`=1, `busy`=0, `in_ready`=1 on the next edge; no `frame_done`; a fresh 0x00 then sends correctly.
